// File: rtl/mmio_pwm_timer.sv
// mmio_pwm_timer: memory-mapped three-channel PWM timer with a millisecond counter.
// Byte/half/word bus access; load data and hit are registered (one-cycle latency).
module mmio_pwm_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int unsigned CLK_HZ    = 12000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  funct3,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        hit,
    output logic        red,
    output logic        green,
    output logic        blue
);
    localparam int unsigned TICKS     = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam logic [31:0] PRESC_MAX = 32'(TICKS - 1);

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    localparam logic [2:0] R_CTRL   = 3'd0;
    localparam logic [2:0] R_PERIOD = 3'd1;
    localparam logic [2:0] R_DUTY_R = 3'd2;
    localparam logic [2:0] R_DUTY_G = 3'd3;
    localparam logic [2:0] R_DUTY_B = 3'd4;
    localparam logic [2:0] R_COUNT  = 3'd5;
    localparam logic [2:0] R_MILLIS = 3'd6;

    logic        ctrl_en;
    logic [31:0] period;
    logic [31:0] duty_r;
    logic [31:0] duty_g;
    logic [31:0] duty_b;
    logic [31:0] count;
    logic [31:0] millis;
    logic [31:0] presc;

    logic [31:0] off;
    logic        in_range;
    logic [2:0]  idx;
    logic [1:0]  lane;

    assign off      = dmem_address - BASE_ADDR;
    assign in_range = (off[31:5] == 27'd0);
    assign idx      = off[4:2];
    assign lane     = off[1:0];

    logic size_ok;
    logic rd_ok;
    logic wr_ok;

    always_comb begin
        size_ok = 1'b0;
        case (funct3)
            F_B, F_BU: size_ok = 1'b1;
            F_H, F_HU: size_ok = ~lane[0];
            F_W:       size_ok = (lane == 2'b00);
            default:   size_ok = 1'b0;
        endcase
    end

    assign rd_ok = in_range && size_ok;
    assign wr_ok = dmem_wren && rd_ok && !funct3[2];

    logic [31:0] rd_word;

    always_comb begin
        rd_word = '0;
        case (idx)
            R_CTRL:   rd_word = {31'd0, ctrl_en};
            R_PERIOD: rd_word = period;
            R_DUTY_R: rd_word = duty_r;
            R_DUTY_G: rd_word = duty_g;
            R_DUTY_B: rd_word = duty_b;
            R_COUNT:  rd_word = count;
            R_MILLIS: rd_word = millis;
            default:  rd_word = '0;
        endcase
    end

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] rd_data;

    assign byte_sel = rd_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        rd_data = '0;
        case (funct3)
            F_B:     rd_data = {{24{byte_sel[7]}}, byte_sel};
            F_BU:    rd_data = {24'd0, byte_sel};
            F_H:     rd_data = {{16{half_sel[15]}}, half_sel};
            F_HU:    rd_data = {16'd0, half_sel};
            F_W:     rd_data = rd_word;
            default: rd_data = '0;
        endcase
    end

    // Store data merged into the current register image, other lanes kept.
    logic [31:0] wr_word;

    always_comb begin
        wr_word = rd_word;
        case (funct3)
            F_B: wr_word[{lane, 3'b000} +: 8] = dmem_data_in[7:0];
            F_H: begin
                if (lane[1]) wr_word[31:16] = dmem_data_in[15:0];
                else         wr_word[15:0]  = dmem_data_in[15:0];
            end
            F_W:     wr_word = dmem_data_in;
            default: wr_word = rd_word;
        endcase
    end

    logic        period_wr;
    logic        en_rise;
    logic        tick;
    logic [31:0] count_next;

    assign period_wr = wr_ok && (idx == R_PERIOD);
    assign en_rise   = wr_ok && (idx == R_CTRL) && !ctrl_en && wr_word[0];
    assign tick      = (presc == PRESC_MAX);

    always_comb begin
        count_next = count;
        if (period_wr || en_rise) begin
            count_next = '0;
        end else if (period == '0) begin
            count_next = '0;
        end else if (ctrl_en) begin
            // >= also catches a count stranded above a shrunken period
            if (count >= period - 32'd1) count_next = '0;
            else                         count_next = count + 32'd1;
        end
    end

    logic pwm_on;
    assign pwm_on = ctrl_en && (period != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en       <= 1'b0;
            period        <= '0;
            duty_r        <= '0;
            duty_g        <= '0;
            duty_b        <= '0;
            count         <= '0;
            millis        <= '0;
            presc         <= '0;
            dmem_data_out <= '0;
            hit           <= 1'b0;
            red           <= 1'b0;
            green         <= 1'b0;
            blue          <= 1'b0;
        end else begin
            presc  <= tick ? '0 : presc + 32'd1;
            millis <= millis + {31'd0, tick};
            count  <= count_next;

            dmem_data_out <= rd_ok ? rd_data : '0;
            hit           <= in_range;

            red   <= pwm_on && (count < duty_r);
            green <= pwm_on && (count < duty_g);
            blue  <= pwm_on && (count < duty_b);

            if (wr_ok) begin
                case (idx)
                    R_CTRL:   ctrl_en <= wr_word[0];
                    R_PERIOD: period  <= wr_word;
                    R_DUTY_R: duty_r  <= wr_word;
                    R_DUTY_G: duty_g  <= wr_word;
                    R_DUTY_B: duty_b  <= wr_word;
                    default:  ;
                endcase
            end
        end
    end
endmodule

// File: doc/mmio_pwm_timer.md
MMIO_PWM_TIMER -- requirements
Module: mmio_pwm_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'hFFFF_FF00, byte address of register offset 0x00.
REQ-002 Parameter CLK_HZ, default 12000000, clock frequency used for the millisecond tick.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port funct3  input  3  access size and sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
REQ-006 Port dmem_wren  input  1  store strobe; one write per cycle high.
REQ-007 Port dmem_address  input  32  byte address of the access.
REQ-008 Port dmem_data_in  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 Port dmem_data_out  output  32  registered load data, extended per funct3.
REQ-010 Port hit  output  1  registered; high one cycle after an address within BASE_ADDR..BASE_ADDR+0x1F.
REQ-011 Ports red, green, blue  output  1 each  active-high PWM channel outputs.

Function
REQ-012 Register map (offset, access): 0x00 CTRL RW (bit0 EN; other bits read 0), 0x04 PERIOD RW 32b, 0x08 DUTY_R RW, 0x0C DUTY_G RW, 0x10 DUTY_B RW, 0x14 COUNT RO, 0x18 MILLIS RO, 0x1C reserved (reads 0).
REQ-013 Writes: sb writes the lane at addr[1:0]; sh writes the half at addr[1]; sw writes the full word; other lanes unchanged.
REQ-014 A misaligned access (sh/lh/lhu with addr[0]=1; sw/lw with addr[1:0]!=0), an out-of-range address, or an unlisted funct3 is ignored for writes and returns 0 for reads.
REQ-015 Writes to COUNT, MILLIS and 0x1C are ignored; hit still asserts.
REQ-016 Read latency is exactly 1 cycle: data for the address presented in cycle N appears on dmem_data_out in cycle N+1, independent of dmem_wren.
REQ-017 Load extraction: lb/lbu select the byte at addr[1:0], lh/lhu select the half at addr[1]; lb/lh sign-extend; lbu/lhu zero-extend; lw returns the whole word.
REQ-018 A read of a register written in the same cycle returns the pre-write value.
REQ-019 COUNT increments every cycle while EN=1 and PERIOD!=0, and wraps from PERIOD-1 to 0.
REQ-020 COUNT holds its value while EN=0; COUNT is 0 while PERIOD=0.
REQ-021 Any write to PERIOD, or to CTRL that changes EN from 0 to 1, loads COUNT to 0 on that edge.
REQ-022 If a write to PERIOD leaves COUNT >= the new PERIOD, COUNT is 0 on the next cycle.
REQ-023 Channel output = EN && PERIOD!=0 && (COUNT < DUTY_x), registered, so each output lags COUNT by one cycle.
REQ-024 Edge cases: DUTY_x=0 gives a constant 0 output; DUTY_x >= PERIOD gives a constant 1 output while enabled.
REQ-025 A DUTY write takes effect from the first comparison after the write edge; there is no shadowing.
REQ-026 MILLIS is free-running regardless of EN.
REQ-027 The prescaler counts 0..CLK_HZ/1000-1; MILLIS increments by 1 on each prescaler wrap.
REQ-028 MILLIS wraps from 32'hFFFF_FFFF to 0.

Reset
REQ-029 While reset is high at a rising clock edge, the following are 0 after that edge: CTRL, PERIOD, DUTY_R/G/B, COUNT, MILLIS, prescaler, dmem_data_out, hit, red, green, blue.
REQ-030 Reset has priority over a simultaneous write.
REQ-031 Reset asserted mid-PWM period forces all outputs low on the next edge.
REQ-032 After reset deasserts, the first write is accepted in the first cycle.

Verification
REQ-033 sw PERIOD=10, DUTY_R=3, CTRL=1 -> red high for exactly 3 of every 10 cycles, COUNT sequence 0..9 repeating.
REQ-034 sw 0x8000_00F0 to DUTY_G, then lb at offset 0x0C -> dmem_data_out=32'hFFFF_FFF0; lbu at 0x0C -> 32'h0000_00F0; lh at 0x0E -> 32'hFFFF_8000; each 1 cycle after the address.
REQ-035 sb 0xAB at offset 0x05 with PERIOD=0 -> PERIOD reads 32'h0000_AB00; sh at offset 0x05 -> ignored, PERIOD unchanged.
REQ-036 DUTY_B=PERIOD=5 with EN=1 -> blue constant 1; DUTY_B=0 -> blue constant 0; PERIOD=0 -> all outputs 0, COUNT=0.
REQ-037 CLK_HZ=4000 -> MILLIS increments every 4 cycles; with MILLIS preloaded via a test force at 32'hFFFF_FFFF, the next tick gives 0.
REQ-038 Reset pulsed while COUNT=7 with a simultaneous sw CTRL -> all registers 0, outputs 0, write lost; lw at 0x40 (out of range) -> data 0, hit 0.
